mdu_mul_issue: RTL and testbench

Issue/response controller in front of the radix-4 multiplier in the RISC-V MDU. Accepts M-extension multiply requests from the CPU over a valid/ready handshake and buffers them in a small FIFO. Maps funct3 onto the multiplier's `mul_type`/operand ports, sequences its `mul_in_valid`/`mul_busy`/`mul_out_valid`/`cpu_busy` handshake, and returns tagged results through a one-entry response register with backpressure and flush.

---
 rtl/mdu_mul_issue.sv | 204 ++++++++++++++++++++
 tb/tb_mdu_mul_issue.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_mul_issue.sv
// Issue/response controller for the MDU radix-4 multiplier: queues M-extension
// multiply requests, sequences the multiplier handshake and returns tagged results.
module mdu_mul_issue #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned TAGW  = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_funct3,
    input  logic [31:0]     req_rs1,
    input  logic [31:0]     req_rs2,
    input  logic [TAGW-1:0] req_rd,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [31:0]     resp_data,
    output logic [TAGW-1:0] resp_rd,
    output logic            resp_err,
    output logic            mul_in_valid,
    output logic [1:0]      mul_type,
    output logic [31:0]     multiplicand,
    output logic [31:0]     multiplier,
    output logic            cpu_busy,
    input  logic            mul_busy,
    input  logic            mul_out_valid,
    input  logic [31:0]     mul_out
);

    localparam int unsigned XLEN = 32;
    localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW   = PW + 1;

    typedef struct packed {
        logic [2:0]      funct3;
        logic [XLEN-1:0] rs1;
        logic [XLEN-1:0] rs2;
        logic [TAGW-1:0] rd;
    } req_t;

    typedef struct packed {
        logic [1:0]      mtype;
        logic [XLEN-1:0] rs1;
        logic [XLEN-1:0] rs2;
        logic [TAGW-1:0] rd;
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DROP
    } state_e;

    state_e          state_q, state_d;
    req_t            mem_q [DEPTH];
    req_t            mem_d [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    op_t             op_q, op_d;
    logic            resp_valid_q, resp_valid_d;
    logic [XLEN-1:0] resp_data_q, resp_data_d;
    logic [TAGW-1:0] resp_rd_q, resp_rd_d;
    logic            resp_err_q, resp_err_d;
    logic            mul_in_valid_q, mul_in_valid_d;

    req_t head;
    logic push;
    logic pop;
    logic resp_free;
    logic head_illegal;
    logic head_zero;

    assign req_ready    = (count_q != CW'(DEPTH));
    assign push         = req_valid && req_ready && !flush;
    assign resp_free    = !resp_valid_q || resp_ready;
    assign head         = mem_q[rd_ptr_q];
    assign head_illegal = head.funct3[2];
    assign head_zero    = (head.rs1 == '0) || (head.rs2 == '0);

    // Must act in the same cycle as mul_out_valid to keep the multiplier in DONE.
    assign cpu_busy = (state_q == S_WAIT) && mul_out_valid && !flush && !resp_free;

    assign resp_valid   = resp_valid_q;
    assign resp_data    = resp_data_q;
    assign resp_rd      = resp_rd_q;
    assign resp_err     = resp_err_q;
    assign mul_in_valid = mul_in_valid_q;
    assign mul_type     = op_q.mtype;
    assign multiplicand = op_q.rs1;
    assign multiplier   = op_q.rs2;

    // Next-state: FIFO bookkeeping, issue sequencing and response register.
    always_comb begin
        state_d        = state_q;
        mem_d          = mem_q;
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        count_d        = count_q;
        op_d           = op_q;
        resp_valid_d   = resp_valid_q;
        resp_data_d    = resp_data_q;
        resp_rd_d      = resp_rd_q;
        resp_err_d     = resp_err_q;
        mul_in_valid_d = 1'b0;
        pop            = 1'b0;

        if (resp_valid_q && resp_ready) begin
            resp_valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (!flush && (count_q != '0) && !mul_busy) begin
                    if (head_illegal || head_zero) begin
                        if (resp_free) begin
                            pop          = 1'b1;
                            resp_valid_d = 1'b1;
                            resp_data_d  = '0;
                            resp_rd_d    = head.rd;
                            resp_err_d   = head_illegal;
                        end
                    end else begin
                        pop            = 1'b1;
                        op_d.mtype     = head.funct3[1:0];
                        op_d.rs1       = head.rs1;
                        op_d.rs2       = head.rs2;
                        op_d.rd        = head.rd;
                        mul_in_valid_d = 1'b1;
                        state_d        = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                state_d = flush ? S_DROP : S_WAIT;
            end
            S_WAIT: begin
                if (flush) begin
                    // A result arriving with the flush is simply dropped.
                    state_d = mul_out_valid ? S_IDLE : S_DROP;
                end else if (mul_out_valid && resp_free) begin
                    resp_valid_d = 1'b1;
                    resp_data_d  = mul_out;
                    resp_rd_d    = op_q.rd;
                    resp_err_d   = 1'b0;
                    state_d      = S_IDLE;
                end
            end
            S_DROP: begin
                if (mul_out_valid) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (push) begin
            mem_d[wr_ptr_q] = '{funct3: req_funct3, rs1: req_rs1, rs2: req_rs2, rd: req_rd};
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        count_d = count_q + CW'(push) - CW'(pop);

        if (flush) begin
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            count_d      = '0;
            resp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            mem_q          <= '{default: '0};
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            op_q           <= '0;
            resp_valid_q   <= 1'b0;
            resp_data_q    <= '0;
            resp_rd_q      <= '0;
            resp_err_q     <= 1'b0;
            mul_in_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            mem_q          <= mem_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            op_q           <= op_d;
            resp_valid_q   <= resp_valid_d;
            resp_data_q    <= resp_data_d;
            resp_rd_q      <= resp_rd_d;
            resp_err_q     <= resp_err_d;
            mul_in_valid_q <= mul_in_valid_d;
        end
    end

endmodule

// File: tb/tb_mdu_mul_issue.sv
// Directed bench for mdu_mul_issue with a behavioural 19-cycle radix-4 multiplier
// model on the far side of the handshake.
module tb_mdu_mul_issue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_funct3;
    logic [31:0] req_rs1;
    logic [31:0] req_rs2;
    logic [4:0]  req_rd;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic [4:0]  resp_rd;
    logic        resp_err;
    logic        mul_in_valid;
    logic [1:0]  mul_type;
    logic [31:0] multiplicand;
    logic [31:0] multiplier;
    logic        cpu_busy;
    logic        mul_busy;
    logic        mul_out_valid;
    logic [31:0] mul_out;

    int n_vec = 0;
    int n_bad = 0;
    int miv_cnt = 0;

    mdu_mul_issue #(.DEPTH(2), .TAGW(5)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_funct3   (req_funct3),
        .req_rs1      (req_rs1),
        .req_rs2      (req_rs2),
        .req_rd       (req_rd),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_data    (resp_data),
        .resp_rd      (resp_rd),
        .resp_err     (resp_err),
        .mul_in_valid (mul_in_valid),
        .mul_type     (mul_type),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .cpu_busy     (cpu_busy),
        .mul_busy     (mul_busy),
        .mul_out_valid(mul_out_valid),
        .mul_out      (mul_out)
    );

    always #5 clk = ~clk;

    // Multiplier model: start pulse at T gives mul_out_valid at T+19, held while cpu_busy.
    typedef enum logic [1:0] {M_IDLE, M_CALC, M_DONE} mst_e;
    mst_e        m_st;
    int          m_cnt;
    logic [31:0] m_res;

    function automatic logic [31:0] mres(input logic [1:0] t, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea;
        logic [63:0] eb;
        logic [63:0] p;
        ea = (t == 2'd3) ? {32'h0, a} : {{32{a[31]}}, a};
        eb = (t[1]) ? {32'h0, b} : {{32{b[31]}}, b};
        p  = ea * eb;
        return (t == 2'd0) ? p[31:0] : p[63:32];
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_st  <= M_IDLE;
            m_cnt <= 0;
            m_res <= '0;
        end else begin
            case (m_st)
                M_IDLE: if (mul_in_valid) begin
                    m_st  <= M_CALC;
                    m_cnt <= 1;
                    m_res <= mres(mul_type, multiplicand, multiplier);
                end
                M_CALC: if (m_cnt == 18) m_st <= M_DONE; else m_cnt <= m_cnt + 1;
                M_DONE: if (!cpu_busy) m_st <= M_IDLE;
                default: m_st <= M_IDLE;
            endcase
            if (mul_in_valid) miv_cnt <= miv_cnt + 1;
        end
    end

    assign mul_busy      = (m_st != M_IDLE);
    assign mul_out_valid = (m_st == M_DONE);
    assign mul_out       = m_res;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        int n;
        n          = 0;
        req_valid  = 1'b1;
        req_funct3 = f3;
        req_rs1    = a;
        req_rs2    = b;
        req_rd     = rd;
        while (!req_ready && n < 200) begin
            tick();
            n++;
        end
        if (!req_ready) chk("push_timeout", 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_resp(input string tag, input int exp_lat, input logic [31:0] exp_d,
                             input logic [4:0] exp_rd, input logic exp_e);
        int n;
        n = 0;
        while (!resp_valid && n < 100) begin
            tick();
            n++;
        end
        chk({tag, "_valid"}, 32'(resp_valid), 32'd1);
        if (exp_lat >= 0) chk({tag, "_lat"}, 32'(n), 32'(exp_lat));
        chk({tag, "_data"}, resp_data, exp_d);
        chk({tag, "_rd"}, 32'(resp_rd), 32'(exp_rd));
        chk({tag, "_err"}, 32'(resp_err), 32'(exp_e));
        tick();
    endtask

    task automatic run_one(input string tag, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] rd, input logic [31:0] exp_d, input logic exp_e,
                           input int exp_lat, input int exp_iss);
        int miv0;
        miv0 = miv_cnt;
        push(f3, a, b, rd);
        wait_resp(tag, exp_lat, exp_d, rd, exp_e);
        chk({tag, "_issues"}, 32'(miv_cnt - miv0), 32'(exp_iss));
        repeat (3) tick();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
        chk({tag, "_resp_data"}, resp_data, 32'd0);
        chk({tag, "_resp_rd"}, 32'(resp_rd), 32'd0);
        chk({tag, "_resp_err"}, 32'(resp_err), 32'd0);
        chk({tag, "_mul_in_valid"}, 32'(mul_in_valid), 32'd0);
        chk({tag, "_mul_type"}, 32'(mul_type), 32'd0);
        chk({tag, "_multiplicand"}, multiplicand, 32'd0);
        chk({tag, "_multiplier"}, multiplier, 32'd0);
        chk({tag, "_cpu_busy"}, 32'(cpu_busy), 32'd0);
    endtask

    initial begin
        int   n;
        int   miv0;
        logic saw;

        rst_n      = 1'b0;
        flush      = 1'b0;
        req_valid  = 1'b0;
        req_funct3 = '0;
        req_rs1    = '0;
        req_rs2    = '0;
        req_rd     = '0;
        resp_ready = 1'b1;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        chk_reset_outputs("init");

        // Single multiplies: latency 21 edges after acceptance, one start pulse each.
        run_one("mulhu",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 32'hFFFF_FFFE, 1'b0, 21, 1);
        run_one("mul",    3'b000, 32'hFFFF_FFFD, 32'h0000_0007, 5'd1, 32'hFFFF_FFEB, 1'b0, 21, 1);
        run_one("mulh",   3'b001, 32'hFFFF_FFFD, 32'h0000_0007, 5'd2, 32'hFFFF_FFFF, 1'b0, 21, 1);
        run_one("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'h0000_0002, 5'd3, 32'hFFFF_FFFF, 1'b0, 21, 1);

        // Zero-operand shortcut and illegal funct3: answered in one edge, no start pulse.
        run_one("zero",    3'b000, 32'h1234_5678, 32'h0000_0000, 5'd8, 32'h0, 1'b0, 1, 0);
        run_one("illegal", 3'b100, 32'h0000_0005, 32'h0000_0006, 5'd9, 32'h0, 1'b1, 1, 0);

        // Three back-to-back requests fill the two-entry queue behind the first issue.
        push(3'b000, 32'd3, 32'd5, 5'd11);
        push(3'b000, 32'd6, 32'd7, 5'd12);
        push(3'b011, 32'h8000_0000, 32'd4, 5'd13);
        chk("b2b_full", 32'(req_ready), 32'd0);
        wait_resp("b2b_a", 19, 32'd15, 5'd11, 1'b0);
        wait_resp("b2b_b", 20, 32'd42, 5'd12, 1'b0);
        wait_resp("b2b_c", 20, 32'd2, 5'd13, 1'b0);
        repeat (3) tick();

        // Backpressure: second result held in the multiplier while the first waits.
        resp_ready = 1'b0;
        push(3'b000, 32'h0000_1000, 32'h0000_0010, 5'd4);
        push(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5);
        n = 0;
        while (!resp_valid && n < 100) begin tick(); n++; end
        chk("bp_first_valid", 32'(resp_valid), 32'd1);
        chk("bp_first_data", resp_data, 32'h0001_0000);
        n = 0;
        while (!mul_out_valid && n < 100) begin tick(); n++; end
        chk("bp_busy_first", 32'(cpu_busy), 32'd1);
        repeat (5) tick();
        chk("bp_busy_held", 32'(cpu_busy), 32'd1);
        chk("bp_done_held", 32'(mul_out_valid), 32'd1);
        chk("bp_resp_kept", resp_data, 32'h0001_0000);
        resp_ready = 1'b1;
        chk("bp_release_rd", 32'(resp_rd), 32'd4);
        tick();
        chk("bp_second_valid", 32'(resp_valid), 32'd1);
        chk("bp_second_data", resp_data, 32'hFFFF_FFFE);
        chk("bp_second_rd", 32'(resp_rd), 32'd5);
        chk("bp_busy_clear", 32'(cpu_busy), 32'd0);
        tick();
        chk("bp_drained", 32'(resp_valid), 32'd0);
        repeat (3) tick();

        // Flush with a held response, a multiply in flight and one request queued.
        resp_ready = 1'b0;
        push(3'b000, 32'h0000_0000, 32'h0000_0009, 5'd10);
        push(3'b000, 32'h0000_0009, 32'h0000_0009, 5'd14);
        push(3'b000, 32'h0000_0003, 32'h0000_0003, 5'd15);
        chk("fl_held_resp", 32'(resp_valid), 32'd1);
        n = 0;
        while (!mul_in_valid && n < 50) begin tick(); n++; end
        chk("fl_issued", 32'(mul_in_valid), 32'd1);
        repeat (5) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl_resp_cleared", 32'(resp_valid), 32'd0);
        resp_ready = 1'b1;
        miv0 = miv_cnt;
        saw  = 1'b0;
        repeat (40) begin
            saw = saw | resp_valid;
            tick();
        end
        chk("fl_no_resp", 32'(saw), 32'd0);
        chk("fl_no_issue", 32'(miv_cnt - miv0), 32'd0);
        chk("fl_mul_idle", 32'(mul_busy), 32'd0);
        run_one("fl_fresh", 3'b011, 32'h0001_0000, 32'h0001_0000, 5'd16, 32'h0000_0001, 1'b0, 21, 1);

        // Reset in the middle of WAIT with a full queue.
        push(3'b011, 32'hFFFF_0000, 32'h0001_0000, 5'd17);
        push(3'b000, 32'd2, 32'd3, 5'd18);
        push(3'b000, 32'd4, 32'd5, 5'd19);
        chk("rst_pre_full", 32'(req_ready), 32'd0);
        repeat (5) tick();
        rst_n = 1'b0;
        tick();
        chk_reset_outputs("midrst");
        rst_n = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
